// File: rtl/imem_arbiter_if.sv
// Request/response bus between the fetch and loader requesters, the arbiter and the memory array.
// The l_lock signal exists only when IMEM_ARB_LOCK_EN is defined.
interface imem_arbiter_if #(
    parameter int n  = 32,
    parameter int AW = 9
);
    logic          f_valid;
    logic          f_ready;
    logic [n-1:0]  f_addr;
    logic          f_rsp_valid;
    logic          f_rsp_err;
    logic [n-1:0]  f_rsp_data;

    logic          l_valid;
    logic          l_ready;
    logic          l_we;
    logic [n-1:0]  l_addr;
    logic [n-1:0]  l_wdata;
    logic          l_rsp_valid;
    logic          l_rsp_err;
    logic [n-1:0]  l_rsp_data;
`ifdef IMEM_ARB_LOCK_EN
    logic          l_lock;
`endif

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [n-1:0]  mem_wdata;
    logic [n-1:0]  mem_rdata;

    // Arbiter side.
    modport slave (
        input  f_valid, f_addr, l_valid, l_we, l_addr, l_wdata, mem_rdata,
        output f_ready, f_rsp_valid, f_rsp_err, f_rsp_data,
        output l_ready, l_rsp_valid, l_rsp_err, l_rsp_data,
        output mem_en, mem_we, mem_addr, mem_wdata
`ifdef IMEM_ARB_LOCK_EN
        , input l_lock
`endif
    );

    // Requester and memory-array side.
    modport master (
        output f_valid, f_addr, l_valid, l_we, l_addr, l_wdata, mem_rdata,
        input  f_ready, f_rsp_valid, f_rsp_err, f_rsp_data,
        input  l_ready, l_rsp_valid, l_rsp_err, l_rsp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata
`ifdef IMEM_ARB_LOCK_EN
        , output l_lock
`endif
    );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing a single-port instruction memory between fetch and loader,
// with address checking and a saturating contention counter. Define IMEM_ARB_LOCK_EN for loader lock.
module imem_arbiter #(
    parameter int n       = 32,
    parameter int ENTRIES = 265,
    parameter int AW      = 9
) (
    input  logic          clk,
    input  logic          rst,
    imem_arbiter_if.slave bus,
    output logic [15:0]   conflict_cnt
);
    localparam logic [n-3:0] LIMIT = (n-2)'(ENTRIES);

    typedef enum logic {
        OWN_FETCH  = 1'b0,
        OWN_LOADER = 1'b1
    } owner_e;

    owner_e       last_grant;
    owner_e       rsp_owner;
    logic         rsp_pending;
    logic         rsp_err_q;
    logic         rsp_read;
    logic         locked;
    logic         grant_f;
    logic         grant_l;
    logic         accept;
    logic         addr_err;
    logic [n-1:0] sel_addr;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        grant_f = 1'b0;
        grant_l = 1'b0;
        if (locked) begin
            grant_l = bus.l_valid;
        end else if (bus.f_valid && bus.l_valid) begin
            if (last_grant == OWN_LOADER) grant_f = 1'b1;
            else                          grant_l = 1'b1;
        end else begin
            grant_f = bus.f_valid;
            grant_l = bus.l_valid;
        end
    end

    assign accept   = grant_f | grant_l;
    assign sel_addr = grant_l ? bus.l_addr : bus.f_addr;
    assign addr_err = (sel_addr[1:0] != 2'b00) || (sel_addr[n-1:2] >= LIMIT);

    assign bus.f_ready   = grant_f;
    assign bus.l_ready   = grant_l;
    // Rejected requests are still accepted but must not touch the array.
    assign bus.mem_en    = accept & ~addr_err;
    assign bus.mem_we    = bus.mem_en & grant_l & bus.l_we;
    assign bus.mem_addr  = sel_addr[AW+1:2];
    assign bus.mem_wdata = bus.l_wdata;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= OWN_LOADER;
            rsp_owner   <= OWN_FETCH;
            rsp_pending <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_read    <= 1'b0;
        end else begin
            rsp_pending <= accept;
            if (accept) begin
                last_grant <= grant_l ? OWN_LOADER : OWN_FETCH;
                rsp_owner  <= grant_l ? OWN_LOADER : OWN_FETCH;
                rsp_err_q  <= addr_err;
                rsp_read   <= ~addr_err & ~(grant_l & bus.l_we);
            end
        end
    end

    // Read data comes straight from the array, which presents it the cycle after mem_en.
    assign bus.f_rsp_valid = rsp_pending & (rsp_owner == OWN_FETCH);
    assign bus.f_rsp_err   = bus.f_rsp_valid & rsp_err_q;
    assign bus.f_rsp_data  = (bus.f_rsp_valid & rsp_read) ? bus.mem_rdata : '0;
    assign bus.l_rsp_valid = rsp_pending & (rsp_owner == OWN_LOADER);
    assign bus.l_rsp_err   = bus.l_rsp_valid & rsp_err_q;
    assign bus.l_rsp_data  = (bus.l_rsp_valid & rsp_read) ? bus.mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (bus.f_valid && bus.l_valid && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

`ifdef IMEM_ARB_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          locked <= 1'b0;
        else if (grant_l) locked <= bus.l_lock;
    end
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: vector tables for grants/strobes, a response scoreboard
// backed by a shadow memory, and hand sequences for reset and (optionally) lock behaviour.
module tb_imem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] conflict_cnt;

    imem_arbiter_if #(.n(32), .AW(9)) bus ();

    imem_arbiter #(.n(32), .ENTRIES(265), .AW(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory array model.
    logic [31:0] mem    [512];
    logic [31:0] shadow [512];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    typedef struct {
        logic        fv;
        logic [31:0] fa;
        logic        lv;
        logic        lwe;
        logic [31:0] la;
        logic [31:0] lwd;
        logic        lk;
        logic        efr;
        logic        elr;
        logic        emen;
        logic        emwe;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t fq[$];
    rsp_t lq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic fv, input logic [31:0] fa, input logic lv,
                                input logic lwe, input logic [31:0] la, input logic [31:0] lwd,
                                input logic lk, input logic efr, input logic elr,
                                input logic emen, input logic emwe);
        vec_t v;
        v.fv = fv; v.fa = fa; v.lv = lv; v.lwe = lwe; v.la = la; v.lwd = lwd; v.lk = lk;
        v.efr = efr; v.elr = elr; v.emen = emen; v.emwe = emwe;
        return v;
    endfunction

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'd265);
    endfunction

    task automatic drive(input vec_t v);
        bus.f_valid = v.fv;
        bus.f_addr  = v.fa;
        bus.l_valid = v.lv;
        bus.l_we    = v.lwe;
        bus.l_addr  = v.la;
        bus.l_wdata = v.lwd;
`ifdef IMEM_ARB_LOCK_EN
        bus.l_lock  = v.lk;
`endif
    endtask

    task automatic check_rsp();
        rsp_t r;
        check("f_rsp_valid", {31'd0, bus.f_rsp_valid}, {31'd0, fq.size() != 0});
        if (fq.size() != 0) begin
            r = fq.pop_front();
            check("f_rsp_err", {31'd0, bus.f_rsp_err}, {31'd0, r.err});
            check("f_rsp_data", bus.f_rsp_data, r.data);
        end
        check("l_rsp_valid", {31'd0, bus.l_rsp_valid}, {31'd0, lq.size() != 0});
        if (lq.size() != 0) begin
            r = lq.pop_front();
            check("l_rsp_err", {31'd0, bus.l_rsp_err}, {31'd0, r.err});
            check("l_rsp_data", bus.l_rsp_data, r.data);
        end
    endtask

    // One cycle: drive, check last cycle's responses and this cycle's grant, predict responses.
    task automatic step(input vec_t v);
        rsp_t r;
        drive(v);
        @(negedge clk);
        check_rsp();
        check("f_ready", {31'd0, bus.f_ready}, {31'd0, v.efr});
        check("l_ready", {31'd0, bus.l_ready}, {31'd0, v.elr});
        check("mem_en",  {31'd0, bus.mem_en},  {31'd0, v.emen});
        check("mem_we",  {31'd0, bus.mem_we},  {31'd0, v.emwe});
        if (v.efr) begin
            r.err  = bad_addr(v.fa);
            r.data = r.err ? 32'd0 : shadow[v.fa[10:2]];
            fq.push_back(r);
        end
        if (v.elr) begin
            r.err = bad_addr(v.la);
            if (r.err || v.lwe) begin
                r.data = 32'd0;
                if (!r.err) shadow[v.la[10:2]] = v.lwd;
            end else begin
                r.data = shadow[v.la[10:2]];
            end
            lq.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t idle;
    vec_t ties[$];
    vec_t main_tbl[$];

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]    = 32'd0;
            shadow[i] = 32'd0;
        end
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle);

        // Both requesters contending right after reset: fetch wins first, then alternate.
        ties.push_back(mk(1, 32'h0, 1, 0, 32'h4, 0, 0, 1, 0, 1, 0));
        ties.push_back(mk(1, 32'h0, 1, 0, 32'h4, 0, 0, 0, 1, 1, 0));
        ties.push_back(mk(1, 32'h0, 1, 0, 32'h4, 0, 0, 1, 0, 1, 0));
        ties.push_back(mk(1, 32'h0, 1, 0, 32'h4, 0, 0, 0, 1, 1, 0));

        main_tbl.push_back(mk(0, 0, 1, 1, 32'h0,   32'hA0, 0, 0, 1, 1, 1));
        main_tbl.push_back(mk(0, 0, 1, 1, 32'h4,   32'hA1, 0, 0, 1, 1, 1));
        main_tbl.push_back(mk(0, 0, 1, 1, 32'h8,   32'hA2, 0, 0, 1, 1, 1));
        main_tbl.push_back(mk(0, 0, 1, 1, 32'h10,  32'hDEADBEEF, 0, 0, 1, 1, 1));
        main_tbl.push_back(mk(1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        main_tbl.push_back(mk(1, 32'h0,  0, 0, 0, 0, 0, 1, 0, 1, 0));
        main_tbl.push_back(mk(1, 32'h4,  0, 0, 0, 0, 0, 1, 0, 1, 0));
        main_tbl.push_back(mk(1, 32'h8,  0, 0, 0, 0, 0, 1, 0, 1, 0));
        main_tbl.push_back(mk(1, 32'h2,  0, 0, 0, 0, 0, 1, 0, 0, 0));
        main_tbl.push_back(mk(0, 0, 1, 0, 32'h424, 0, 0, 0, 1, 0, 0));
        main_tbl.push_back(mk(0, 0, 1, 0, 32'h420, 0, 0, 0, 1, 1, 0));
        main_tbl.push_back(mk(0, 0, 1, 0, 32'h10,  0, 0, 0, 1, 1, 0));
        main_tbl.push_back(mk(1, 32'h4, 1, 1, 32'h20, 32'h55, 0, 1, 0, 1, 0));
        main_tbl.push_back(mk(1, 32'h8, 1, 1, 32'h20, 32'h55, 0, 0, 1, 1, 1));
        main_tbl.push_back(mk(1, 32'h20, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        main_tbl.push_back(idle);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst f_rsp_valid", {31'd0, bus.f_rsp_valid}, 32'd0);
        check("rst l_rsp_valid", {31'd0, bus.l_rsp_valid}, 32'd0);
        check("rst l_rsp_data", bus.l_rsp_data, 32'd0);
        check("rst conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
        check("rst f_ready", {31'd0, bus.f_ready}, 32'd0);
        check("rst mem_en", {31'd0, bus.mem_en}, 32'd0);
        rst = 1'b0;

        foreach (ties[i]) step(ties[i]);
        check("conflict_cnt after ties", {16'd0, conflict_cnt}, 32'd4);

        foreach (main_tbl[i]) step(main_tbl[i]);
        check("conflict_cnt after main", {16'd0, conflict_cnt}, 32'd6);

        // Reset right after a fetch accept drops the response and restores fetch priority.
        step(mk(1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        drive(idle);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fq.delete();
        lq.delete();
        check("post-rst f_rsp_valid", {31'd0, bus.f_rsp_valid}, 32'd0);
        check("post-rst conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
        step(mk(1, 32'h4, 1, 0, 32'h8, 0, 0, 1, 0, 1, 0));
        step(idle);

`ifdef IMEM_ARB_LOCK_EN
        step(mk(0, 0, 1, 1, 32'h30, 32'h77, 1, 0, 1, 1, 1));
        repeat (3) step(mk(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(1, 32'h0, 1, 0, 32'h30, 0, 0, 0, 1, 1, 0));
        step(mk(1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        step(idle);
        check("lock conflict_cnt", {16'd0, conflict_cnt}, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
